// File: rtl/cpu_defs.sv
// Shared definitions for the bit-count coprocessor that sits beside the MDU.
// Holds the op encodings, the sequencer state encoding and the width of the
// accumulated count.
package cpu_defs;

    localparam logic OP_CNT_ONES  = 1'b0;
    localparam logic OP_CNT_ZEROS = 1'b1;

    // A 32-bit operand has at most 32 set bits, so six bits hold every count
    localparam int CNT_W = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/chunk_popcount.sv
// Combinational ones-counter for one W-bit chunk, built as a balanced adder
// tree.  The tree is laid out heap-style: leaves hold single bits, and each
// inner node adds its two children.  W is expected to be a power of two.
module chunk_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             data_i,
    output logic [$clog2(W+1)-1:0]   count_o
);

    localparam int CW    = $clog2(W + 1);
    localparam int NODES = 2 * W - 1;

    // Fill the leaves from the input bits, then reduce pairwise up to the root
    always_comb begin
        logic [CW-1:0] node [NODES];
        for (int i = 0; i < NODES; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < W; i++) begin
            node[W - 1 + i] = CW'(data_i[i]);
        end
        for (int i = W - 2; i >= 0; i--) begin
            node[i] = node[2 * i + 1] + node[2 * i + 2];
        end
        count_o = node[0];
    end

endmodule

// File: rtl/popcnt_seq_unit.sv
// Multi-cycle bit-count coprocessor.  One chunk counter is reused every cycle:
// the operand sits in a shift register, the low chunk is counted and added to
// an accumulator, and after N_STEPS cycles the total is committed to the
// readable result register with a one-cycle done pulse.  Counting zeros is
// done by inverting the operand on capture, so the datapath only ever counts
// ones.  The pipeline stalls on busy, and abort kills an operation in flight
// without touching the committed result.
module popcnt_seq_unit
    import cpu_defs::*;
#(
    parameter int CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] din,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int N_STEPS     = 32 / CHUNK_W;
    localparam int CHUNK_CNT_W = $clog2(CHUNK_W + 1);
    localparam int STEP_W      = 5;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

    state_t              state_q;
    logic [31:0]         shiftReg_q;
    logic [CNT_W-1:0]    acc_q;
    logic [STEP_W-1:0]   step_q;
    logic [31:0]         result_q;
    logic                busy_q;
    logic                done_q;

    logic [CHUNK_CNT_W-1:0] chunkCount;
    logic [CNT_W-1:0]       accSum_d;

    chunk_popcount #(
        .W (CHUNK_W)
    ) uChunkCount (
        .data_i  (shiftReg_q[CHUNK_W-1:0]),
        .count_o (chunkCount)
    );

    // Running total including the chunk currently at the bottom of the shifter
    always_comb begin
        accSum_d = acc_q + CNT_W'(chunkCount);
    end

    // Sequencer: capture on start, walk the operand one chunk per cycle, then
    // commit; busy and done are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shiftReg_q <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        shiftReg_q <= (op == OP_CNT_ONES) ? din : ~din;
                        acc_q      <= '0;
                        step_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    done_q <= 1'b0;
                    if (abort) begin
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (step_q == LAST_STEP) begin
                        result_q <= {{(32 - CNT_W){1'b0}}, accSum_d};
                        acc_q    <= '0;
                        step_q   <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        acc_q      <= accSum_d;
                        shiftReg_q <= shiftReg_q >> CHUNK_W;
                        step_q     <= step_q + STEP_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
